// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default fetch widths, opcode constants and the
// fetch-stage FSM encodings.
package cpu_pkg;

   localparam int PC_W_DEF    = 10;
   localparam int INSTR_W_DEF = 32;

   typedef logic [3:0] opcode_t;

   localparam opcode_t OPC_ALU = 4'h1;
   localparam opcode_t OPC_MEM = 4'h2;
   localparam opcode_t OPC_MOV = 4'h8;
   localparam opcode_t OPC_BR  = 4'hC;
   localparam opcode_t OPC_NOP = 4'hF;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   function automatic logic is_nop(input opcode_t opc);
      return opc == OPC_NOP;
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: DEPTH x W storage with push/pop/clear and a registered head
// so the consumer sees a stable word with no read latency.
module ifetch_fifo #(
   parameter int  W     = 42,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          head_valid,
   output logic [LW-1:0] level
);

   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [LW-1:0] level_reg;
   logic [LW-1:0] level_next;
   logic [W-1:0]  head_reg;
   logic [W-1:0]  head_next;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (level_reg != '0);
   assign do_push = push && ((level_reg != FULL_LEVEL) || do_pop);

   always_comb begin
      level_next = level_reg;
      case ({do_push, do_pop})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   // Head is refreshed from the next stored entry, or bypassed from the push
   // data when the queue is (or is about to become) empty.
   always_comb begin
      head_next = head_reg;
      if (do_pop && (level_reg > LW'(1))) begin
         head_next = mem[rd_ptr_reg + AW'(1)];
      end else if (do_push && ((level_reg == '0) || (do_pop && (level_reg == LW'(1))))) begin
         head_next = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         level_reg  <= '0;
         head_reg   <= '0;
      end else if (clear) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         level_reg <= level_next;
         head_reg  <= head_next;
      end
   end

   assign head       = head_reg;
   assign head_valid = (level_reg != '0);
   assign level      = level_reg;

endmodule

// File: rtl/instr_prefetch.sv
// Fetch stage: owns the fetch PC, issues one ROM read per cycle against queue
// credit, and flushes on redirect. Define IFETCH_SKIP_NOP_EN to drop no-ops.
module instr_prefetch
   import cpu_pkg::*;
#(
   parameter int  PC_W    = PC_W_DEF,
   parameter int  INSTR_W = INSTR_W_DEF,
   parameter int  DEPTH   = 4,
   localparam int LW      = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   output logic               rom_rd,
   output logic [PC_W-1:0]    rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [LW-1:0]      level
);

   localparam int          EW         = INSTR_W + PC_W;
   localparam logic [LW:0] CREDIT_MAX = (LW + 1)'(DEPTH);

   logic [PC_W-1:0] fetch_pc_reg;
   logic [PC_W-1:0] fetch_pc_next;
   logic [PC_W-1:0] issued_pc_reg;
   logic            inflight_reg;
   logic [1:0]      state_reg;
   logic [1:0]      state_next;
   logic [LW-1:0]   fifo_level;
   logic [LW:0]     credit_used;
   logic            kill;
   logic            drop_nop;
   logic            push_en;
   logic [EW-1:0]   head;

   // Registered level plus outstanding read: a same-cycle pop frees no credit.
   assign credit_used = {1'b0, fifo_level} + {{LW{1'b0}}, inflight_reg};
   assign rom_rd      = !rst && !redirect && (credit_used < CREDIT_MAX);
   assign rom_addr    = rst ? '0 : fetch_pc_reg;

   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      if (redirect) begin
         fetch_pc_next = redirect_pc;
      end else if (rom_rd) begin
         fetch_pc_next = fetch_pc_reg + PC_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  state_next = redirect ? ST_FLUSH : ST_RUN;
         ST_RUN:   state_next = redirect ? ST_FLUSH : ST_RUN;
         ST_FLUSH: state_next = redirect ? ST_FLUSH : ST_RUN;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg  <= '0;
         issued_pc_reg <= '0;
         inflight_reg  <= 1'b0;
         state_reg     <= ST_IDLE;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         inflight_reg <= rom_rd;
         if (rom_rd) begin
            issued_pc_reg <= fetch_pc_reg;
         end
         state_reg <= state_next;
      end
   end

   // A return from before the redirect must never reach the cleared queue.
   assign kill = redirect || ((state_reg == ST_FLUSH) && inflight_reg);

`ifdef IFETCH_SKIP_NOP_EN
   assign drop_nop = is_nop(rom_data[INSTR_W-1 -: 4]);
`else
   assign drop_nop = 1'b0;
`endif

   assign push_en = inflight_reg && !kill && !drop_nop;

   ifetch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (redirect),
      .push       (push_en),
      .push_data  ({rom_data, issued_pc_reg}),
      .pop        (out_ready),
      .head       (head),
      .head_valid (out_valid),
      .level      (fifo_level)
   );

   assign out_instr = head[EW-1 -: INSTR_W];
   assign out_pc    = head[PC_W-1:0];
   assign level     = fifo_level;

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized scoreboard bench for instr_prefetch with directed latency,
// fill, redirect, wrap and mid-stream reset scenarios.
module tb_instr_prefetch;

   localparam int PC_W    = 10;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 4;
   localparam int LW      = $clog2(DEPTH) + 1;

   logic               clk;
   logic               rst;
   logic               rom_rd;
   logic [PC_W-1:0]    rom_addr;
   logic [INSTR_W-1:0] rom_data;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic [LW-1:0]      level;

   instr_prefetch #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_rd      (rom_rd),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .level       (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program memory: ROM[i]=i with a few no-ops and branch words sprinkled in.
   logic [INSTR_W-1:0] rom [1 << PC_W];
   initial begin
      for (int i = 0; i < (1 << PC_W); i++) begin
         rom[i] = 32'(i);
         if (i % 11 == 3) rom[i] = 32'hC000_0000 | 32'(i);
         if (i % 37 == 5) rom[i] = 32'hF000_0000 | 32'(i);
      end
      rom[2] = 32'hF000_0000;
   end

   always @(posedge clk) begin
      if (rom_rd) rom_data <= rom[rom_addr];
      else        rom_data <= $urandom();
   end

   int checks = 0;
   int errors = 0;
   int delivered = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_skipped(input logic [31:0] w);
`ifdef IFETCH_SKIP_NOP_EN
      return w[31:28] == 4'hF;
`else
      return 1'b0;
`endif
   endfunction

   // Scoreboard: expected delivery stream is simply consecutive PCs from the
   // last restart point, minus any skipped no-ops.
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } exp_t;

   exp_t            exp_q[$];
   logic [PC_W-1:0] gen_pc;

   task automatic sb_refill();
      while (exp_q.size() < 16) begin
         if (!is_skipped(rom[gen_pc])) exp_q.push_back('{gen_pc, rom[gen_pc]});
         gen_pc = gen_pc + 1'b1;
      end
   endtask

   task automatic sb_restart(input logic [PC_W-1:0] pc);
      exp_q.delete();
      gen_pc = pc;
      sb_refill();
   endtask

   logic               prev_hold = 1'b0;
   logic [PC_W-1:0]    prev_pc;
   logic [INSTR_W-1:0] prev_instr;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb_restart('0);
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pc", 32'(out_pc), 32'(prev_pc));
            chk("hold_instr", out_instr, prev_instr);
         end
         if (level == LW'(DEPTH)) chk("full_no_read", 32'(rom_rd), 32'd0);
         if (redirect) chk("redirect_no_read", 32'(rom_rd), 32'd0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow actual_pc=%h required=none t=%0t", out_pc, $time);
            end else begin
               e = exp_q.pop_front();
               $display("pop pc=%h instr=%h exp_pc=%h", out_pc, out_instr, e.pc);
               chk("sb_pc", 32'(out_pc), 32'(e.pc));
               chk("sb_instr", out_instr, e.instr);
               delivered++;
               sb_refill();
            end
         end
         prev_hold  = out_valid && !out_ready && !redirect;
         prev_pc    = out_pc;
         prev_instr = out_instr;
         if (redirect) sb_restart(redirect_pc);
      end
   end

   task automatic pulse_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   initial begin
      int reads;
      int exp_reads;
      int got;
      bit hit;
      logic [PC_W-1:0] a;

      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      out_ready = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rom_rd", 32'(rom_rd), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", 32'(out_pc), 32'd0);
      chk("rst_level", 32'(level), 32'd0);

      // Reset release: one read per cycle, first out_valid two cycles later
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t1_rom_rd", 32'(rom_rd), 32'd1);
         chk("t1_rom_addr", 32'(rom_addr), 32'(k));
         if (k < 2)      chk("t1_valid_low", 32'(out_valid), 32'd0);
         else if (k < 4) chk("t1_valid_high", 32'(out_valid), 32'd1);
      end
      repeat (10) @(posedge clk);

      // Fill with out_ready low
      @(posedge clk); #1 out_ready = 1'b0;
      pulse_reset();
      exp_reads = 0;
      got = 0;
      while (got < DEPTH) begin
         if (!is_skipped(rom[exp_reads])) got++;
         exp_reads++;
      end
      reads = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rom_rd) reads++;
      end
      chk("t2_reads", 32'(reads), 32'(exp_reads));
      chk("t2_level", 32'(level), 32'(DEPTH));
      chk("t2_rom_rd", 32'(rom_rd), 32'd0);
      @(posedge clk); #1 out_ready = 1'b1;
      hit = 1'b0;
      for (int k = 0; k < 6 && !hit; k++) begin
         @(negedge clk);
         if (rom_rd) begin
            hit = 1'b1;
            chk("t2_resume_addr", 32'(rom_addr), 32'(exp_reads));
         end
      end
      chk("t2_resume_seen", 32'(hit), 32'd1);
      repeat (8) @(posedge clk);

      // Redirect at level 3 with a read in flight
      @(posedge clk); #1 out_ready = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 10 && !hit; k++) begin
         @(posedge clk); #1;
         if (level == LW'(3)) hit = 1'b1;
      end
      chk("t3_level3_seen", 32'(hit), 32'd1);
      redirect = 1'b1;
      redirect_pc = 10'h100;
      @(posedge clk); #1 redirect = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("t3_level_cleared", 32'(level), 32'd0);
      chk("t3_rom_rd", 32'(rom_rd), 32'd1);
      chk("t3_rom_addr", 32'(rom_addr), 32'h100);
      hit = 1'b0;
      for (int k = 0; k < 6 && !hit; k++) begin
         if (out_valid) begin
            hit = 1'b1;
            chk("t3_first_pc", 32'(out_pc), 32'h100);
         end else begin
            @(negedge clk);
         end
      end
      chk("t3_valid_seen", 32'(hit), 32'd1);
      repeat (6) @(posedge clk);

      // PC wrap
      @(posedge clk); #1 redirect = 1'b1; redirect_pc = 10'h3FE;
      @(posedge clk); #1 redirect = 1'b0;
      a = 10'h3FE;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_rom_rd", 32'(rom_rd), 32'd1);
         chk("t4_rom_addr", 32'(rom_addr), 32'(a));
         a = a + 1'b1;
      end
      repeat (6) @(posedge clk);

      // Reset mid-stream at level 2
      @(posedge clk); #1 out_ready = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 10 && !hit; k++) begin
         if (level == LW'(2)) hit = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("t6_level2_seen", 32'(hit), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_rom_rd", 32'(rom_rd), 32'd1);
      chk("t6_rom_addr", 32'(rom_addr), 32'd0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         out_ready   = ($urandom_range(0, 9) < 7);
         redirect    = ($urandom_range(0, 99) < 3);
         redirect_pc = PC_W'($urandom());
         rst         = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      redirect  = 1'b0;
      rst       = 1'b0;
      repeat (20) @(posedge clk);
      chk("delivered_enough", 32'(delivered > 500), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
